// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Requester 0 is the core execute stage; requester 1 is the DMA/peripheral side.
// A request is granted round-robin and its operands are latched. The ALU is
// driven for one EXEC cycle, and its result is returned on a valid/ready
// response channel. The block also owns the {Z,C,S,O} status register that
// feeds the ALU CFlags input.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (ready is combinational, one-hot or zero)
//   req_op1/op2/mode/setf per-requester payload, requester 0 in the low slice
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/data/flags     owner, result and carry-masked flags of the response
//   status                status register {Z,C,S,O}
//   alu_op1/op2/mode/en   drive to the ALU; alu_cflags mirrors status
//   alu_out/alu_flags     result and flags returned by the ALU
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int MODE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_op1,
  input  logic [2*DATA_W-1:0] req_op2,
  input  logic [2*MODE_W-1:0] req_mode,
  input  logic [1:0]          req_setf,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [3:0]          rsp_flags,
  output logic [3:0]          status,
  output logic [DATA_W-1:0]   alu_op1,
  output logic [DATA_W-1:0]   alu_op2,
  output logic [MODE_W-1:0]   alu_mode,
  output logic                alu_en,
  output logic [3:0]          alu_cflags,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic [3:0]          alu_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q,     state_d;
  logic                prio_q,      prio_d;
  logic [3:0]          status_q,    status_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q,    rsp_id_d;
  logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
  logic [3:0]          rsp_flags_q, rsp_flags_d;
  logic [DATA_W-1:0]   op1_q,       op1_d;
  logic [DATA_W-1:0]   op2_q,       op2_d;
  logic [MODE_W-1:0]   mode_q,      mode_d;
  logic                setf_q,      setf_d;

  logic                gnt_vld;
  logic                gnt_id;

  // The ALU leaves carry undefined outside its arithmetic modes. For those
  // modes the previous C is carried forward instead of a meaningless bit.
  function automatic logic [3:0] mask_carry(input logic [MODE_W-1:0] mode,
                                            input logic [3:0]        flags,
                                            input logic              old_c);
    logic arith;
    arith = (mode == MODE_W'(0))  || (mode == MODE_W'(1)) ||
            (mode == MODE_W'(7))  || (mode == MODE_W'(8)) ||
            (mode == MODE_W'(9))  || (mode == MODE_W'(15));
    return {flags[3], (arith ? flags[2] : old_c), flags[1], flags[0]};
  endfunction

  // A lone requester always wins; prio only breaks ties.
  always_comb begin
    gnt_vld = |req_valid;
    gnt_id  = prio_q;
    if (req_valid == 2'b01) gnt_id = 1'b0;
    else if (req_valid == 2'b10) gnt_id = 1'b1;
  end

  // Gated by rst_n so no handshake can complete while reset is held.
  assign req_ready = (rst_n && (state_q == IDLE) && gnt_vld) ?
                     (gnt_id ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    status_d    = status_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    mode_d      = mode_q;
    setf_d      = setf_q;
    case (state_q)
      // IDLE: accept and latch the granted payload
      IDLE: begin
        if (gnt_vld) begin
          op1_d    = gnt_id ? req_op1[2*DATA_W-1:DATA_W] : req_op1[DATA_W-1:0];
          op2_d    = gnt_id ? req_op2[2*DATA_W-1:DATA_W] : req_op2[DATA_W-1:0];
          mode_d   = gnt_id ? req_mode[2*MODE_W-1:MODE_W] : req_mode[MODE_W-1:0];
          setf_d   = req_setf[gnt_id];
          rsp_id_d = gnt_id;
          state_d  = EXEC;
        end
      end
      // EXEC: ALU is driven, capture result and flags
      EXEC: begin
        rsp_data_d  = alu_out;
        rsp_flags_d = mask_carry(mode_q, alu_flags, status_q[2]);
        if (setf_q) status_d = mask_carry(mode_q, alu_flags, status_q[2]);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      // RESP: hold the response until consumed, then hand priority over
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          prio_d      = ~rsp_id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      status_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      mode_q      <= '0;
      setf_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      status_q    <= status_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      mode_q      <= mode_d;
      setf_q      <= setf_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign status     = status_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_mode   = mode_q;
  assign alu_en     = (state_q == EXEC);
  assign alu_cflags = status_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small behavioural ALU
// attached to the ALU-side ports.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_op1, req_op2;
  logic [7:0]  req_mode;
  logic [1:0]  req_setf;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [7:0]  rsp_data;
  logic [3:0]  rsp_flags, status;
  logic [7:0]  alu_op1, alu_op2, alu_out;
  logic [3:0]  alu_mode, alu_cflags, alu_flags;
  logic        alu_en;

  int n_assert = 0;
  int n_fail   = 0;

  alu_arbiter #(.DATA_W(8), .MODE_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_mode(req_mode), .req_setf(req_setf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .status(status),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_mode(alu_mode), .alu_en(alu_en),
    .alu_cflags(alu_cflags), .alu_out(alu_out), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  // ALU: 0 add, 1 sub (C = borrow), 2 OR, 4 AND, others XOR; logic modes report C=0
  logic [8:0] alu_sum;
  logic       alu_c, alu_o;
  always_comb begin
    alu_sum = '0;
    alu_out = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (alu_mode)
      4'd0: begin
        alu_sum = {1'b0, alu_op1} + {1'b0, alu_op2};
        alu_out = alu_sum[7:0];
        alu_c   = alu_sum[8];
        alu_o   = (alu_op1[7] == alu_op2[7]) && (alu_out[7] != alu_op1[7]);
      end
      4'd1: begin
        alu_out = alu_op1 - alu_op2;
        alu_c   = (alu_op1 < alu_op2);
        alu_o   = (alu_op1[7] != alu_op2[7]) && (alu_out[7] != alu_op1[7]);
      end
      4'd2:    alu_out = alu_op1 | alu_op2;
      4'd4:    alu_out = alu_op1 & alu_op2;
      default: alu_out = alu_op1 ^ alu_op2;
    endcase
    alu_flags = {(alu_out == 8'h00), alu_c, alu_out[7], alu_o};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] m, input logic s);
    if (r == 0) begin
      req_op1[7:0] = a; req_op2[7:0] = b; req_mode[3:0] = m; req_setf[0] = s;
    end else begin
      req_op1[15:8] = a; req_op2[15:8] = b; req_mode[7:4] = m; req_setf[1] = s;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0] exp_gnt  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [7:0] exp_data [4] = '{8'h36, 8'h00, 8'h36, 8'h00};
  logic [3:0] exp_flg  [4] = '{4'b0000, 4'b1100, 4'b0100, 4'b1100};
  logic [3:0] exp_st   [4] = '{4'b0011, 4'b1100, 4'b1100, 4'b1100};

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; req_op1 = '0; req_op2 = '0;
    req_mode = '0; req_setf = '0; rsp_ready = 1'b1;
    #3 req_valid = 2'b11;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_status", 32'(status), 32'h0);
    chk("rst_alu_en", 32'(alu_en), 32'h0);
    chk("rst_alu_op1", 32'(alu_op1), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    req_valid = 2'b00;
    @(negedge clk) rst_n = 1'b1;
    cyc();

    // single add from requester 0
    set_req(0, 8'h7F, 8'h01, 4'd0, 1'b1);
    req_valid = 2'b01;
    #1 chk("add_req_ready", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("add_alu_en", 32'(alu_en), 32'h1);
    chk("add_alu_op1", 32'(alu_op1), 32'h7F);
    chk("add_alu_op2", 32'(alu_op2), 32'h01);
    chk("add_alu_mode", 32'(alu_mode), 32'h0);
    chk("add_rsp_early", 32'(rsp_valid), 32'h0);
    cyc();
    chk("add_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("add_rsp_data", 32'(rsp_data), 32'h80);
    chk("add_rsp_id", 32'(rsp_id), 32'h0);
    chk("add_rsp_flags", 32'(rsp_flags), 32'h3);
    chk("add_status", 32'(status), 32'h3);
    chk("add_alu_en_off", 32'(alu_en), 32'h0);
    chk("add_op1_hold", 32'(alu_op1), 32'h7F);
    cyc();
    chk("add_rsp_clear", 32'(rsp_valid), 32'h0);

    // setf=0 subtract from requester 1
    set_req(1, 8'h05, 8'h05, 4'd1, 1'b0);
    req_valid = 2'b10;
    #1 chk("sub_req_ready", 32'(req_ready), 32'h2);
    cyc();
    req_valid = 2'b00;
    #1 chk("sub_cflags", 32'(alu_cflags), 32'h3);
    cyc();
    chk("sub_rsp_data", 32'(rsp_data), 32'h00);
    chk("sub_rsp_id", 32'(rsp_id), 32'h1);
    chk("sub_rsp_flags", 32'(rsp_flags), 32'h8);
    chk("sub_status", 32'(status), 32'h3);
    cyc();

    // contention: both valid, grants alternate starting with requester 0
    set_req(0, 8'h12, 8'h34, 4'd2, 1'b0);
    set_req(1, 8'hFF, 8'h01, 4'd0, 1'b1);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("rr%0d_grant", i), 32'(req_ready), 32'(exp_gnt[i]));
      cyc();
      cyc();
      chk($sformatf("rr%0d_resp_ready", i), 32'(req_ready), 32'h0);
      chk($sformatf("rr%0d_rsp_id", i), 32'(rsp_id), 32'(exp_gnt[i][1]));
      chk($sformatf("rr%0d_rsp_data", i), 32'(rsp_data), 32'(exp_data[i]));
      chk($sformatf("rr%0d_rsp_flags", i), 32'(rsp_flags), 32'(exp_flg[i]));
      chk($sformatf("rr%0d_status", i), 32'(status), 32'(exp_st[i]));
      cyc();
    end
    req_valid = 2'b00;

    // carry masking: add sets C, then a logic op keeps it
    set_req(0, 8'h80, 8'h80, 4'd0, 1'b1);
    req_valid = 2'b01;
    #1;
    cyc();
    req_valid = 2'b00;
    cyc();
    chk("cm_add_data", 32'(rsp_data), 32'h00);
    chk("cm_add_flags", 32'(rsp_flags), 32'hD);
    chk("cm_add_status", 32'(status), 32'hD);
    cyc();
    set_req(0, 8'hF0, 8'h0F, 4'd4, 1'b1);
    req_valid = 2'b01;
    #1 chk("cm_and_ready", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 2'b00;
    #1 chk("cm_and_cflags", 32'(alu_cflags), 32'hD);
    cyc();
    chk("cm_and_data", 32'(rsp_data), 32'h00);
    chk("cm_and_flags", 32'(rsp_flags), 32'hC);
    chk("cm_and_status", 32'(status), 32'hC);
    cyc();

    // backpressure with requester 1 waiting
    set_req(0, 8'h03, 8'h04, 4'd0, 1'b0);
    set_req(1, 8'h80, 8'h80, 4'd0, 1'b1);
    req_valid = 2'b01;
    #1 chk("bp_accept", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 2'b10;
    rsp_ready = 1'b0;
    #1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp%0d_data", i), 32'(rsp_data), 32'h07);
      chk($sformatf("bp%0d_id", i), 32'(rsp_id), 32'h0);
      chk($sformatf("bp%0d_flags", i), 32'(rsp_flags), 32'h0);
      chk($sformatf("bp%0d_status", i), 32'(status), 32'hC);
      chk($sformatf("bp%0d_ready", i), 32'(req_ready), 32'h0);
      cyc();
    end
    chk("bp_still_valid", 32'(rsp_valid), 32'h1);
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'h0);
    cyc();
    chk("bp_req1_grant", 32'(req_ready), 32'h2);
    cyc();
    req_valid = 2'b00;
    cyc();
    chk("bp_req1_id", 32'(rsp_id), 32'h1);
    chk("bp_req1_data", 32'(rsp_data), 32'h00);
    chk("bp_req1_flags", 32'(rsp_flags), 32'hD);
    chk("bp_req1_status", 32'(status), 32'hD);
    cyc();

    // asynchronous reset during EXEC
    set_req(0, 8'h7F, 8'h01, 4'd0, 1'b1);
    req_valid = 2'b01;
    #1;
    cyc();
    req_valid = 2'b00;
    #1 chk("ar_alu_en", 32'(alu_en), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_alu_en_off", 32'(alu_en), 32'h0);
    chk("ar_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("ar_status", 32'(status), 32'h0);
    chk("ar_alu_op1", 32'(alu_op1), 32'h0);
    chk("ar_cflags", 32'(alu_cflags), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("ar%0d_no_rsp", i), 32'(rsp_valid), 32'h0);
      chk($sformatf("ar%0d_status", i), 32'(status), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
